m16_simd_accum: RTL and testbench

Multi-beat SIMD accumulate sequencer for the M16 partitioned 16-bit datapath. It accepts a command (lane width, saturate mode, beat count), streams that many 16-bit operands over a valid/ready handshake, and sums them per lane into an internal accumulator. Carry propagation and saturation are controlled per lane. It sits between the instruction issue stage and writeback, and returns one result word plus sticky per-lane overflow flags.

---
 rtl/m16_pkg.sv | 41 ++++
 rtl/m16_simd_add.sv | 60 ++++++
 rtl/m16_simd_accum.sv | 112 +++++++++++
 tb/tb_m16_simd_accum.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/m16_pkg.sv
// Shared definitions for the M16 partitioned datapath: lane width
// encodings, sequencer states, lane saturation limits and small helpers.
package m16_pkg;

  localparam logic [1:0] W4  = 2'b00;
  localparam logic [1:0] W8  = 2'b01;
  localparam logic [1:0] W16 = 2'b10;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  localparam logic [3:0]  LMAX4  = 4'h7;
  localparam logic [3:0]  LMIN4  = 4'h8;
  localparam logic [7:0]  LMAX8  = 8'h7F;
  localparam logic [7:0]  LMIN8  = 8'h80;
  localparam logic [15:0] LMAX16 = 16'h7FFF;
  localparam logic [15:0] LMIN16 = 16'h8000;

  // The reserved encoding 2'b11 behaves as a single 16-bit lane.
  function automatic logic [1:0] norm_width(input logic [1:0] w);
    return (w == 2'b11) ? W16 : w;
  endfunction

  // Index of the top nibble of the lane that contains nibble k.
  function automatic int lane_top(input logic [1:0] w, input int k);
    case (w)
      W4:      return k;
      W8:      return k | 1;
      default: return 3;
    endcase
  endfunction

  // Full-word clamp pattern; every lane is filled with its max or min.
  function automatic logic [15:0] clamp_pat(input logic [1:0] w, input logic neg);
    case (w)
      W4:      return neg ? {4{LMIN4}} : {4{LMAX4}};
      W8:      return neg ? {2{LMIN8}} : {2{LMAX8}};
      default: return neg ? LMIN16 : LMAX16;
    endcase
  endfunction

endpackage

// File: rtl/m16_simd_add.sv
// Partitioned 16-bit adder: four nibble slices, carry gated at each lane
// boundary, signed overflow reported at each lane's top nibble index and
// optional per-lane clamp to the lane max/min.
module m16_simd_add
  import m16_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic [1:0]  i_width,
  input  logic        i_sat,
  output logic [15:0] o_sum,
  output logic [3:0]  o_ovf
);

  logic [1:0]  w_w;
  logic [15:0] w_raw;
  logic [3:0]  w_lov;

  assign w_w   = norm_width(i_width);
  assign o_ovf = w_lov;

  // Nibble carry chain; the carry is dropped when a new lane starts.
  always_comb begin
    logic       c;
    logic [4:0] t;
    w_raw = '0;
    c     = 1'b0;
    t     = '0;
    for (int k = 0; k < 4; k++) begin
      if (k == 0 || lane_top(w_w, k - 1) == k - 1) c = 1'b0;
      t = {1'b0, i_a[4*k +: 4]} + {1'b0, i_b[4*k +: 4]} + {4'b0, c};
      w_raw[4*k +: 4] = t[3:0];
      c = t[4];
    end
  end

  // Signed overflow per lane, flagged only at the lane's top nibble.
  always_comb begin
    w_lov = '0;
    for (int k = 0; k < 4; k++) begin
      if (lane_top(w_w, k) == k)
        w_lov[k] = (i_a[4*k+3] == i_b[4*k+3]) && (w_raw[4*k+3] != i_a[4*k+3]);
    end
  end

  // Clamp each nibble of an overflowed lane; direction follows operand sign.
  always_comb begin
    int          tk;
    logic [15:0] pat;
    o_sum = w_raw;
    tk    = 0;
    pat   = '0;
    for (int k = 0; k < 4; k++) begin
      tk  = lane_top(w_w, k);
      pat = clamp_pat(w_w, i_a[4*tk+3]);
      if (i_sat && w_lov[tk]) o_sum[4*k +: 4] = pat[4*k +: 4];
    end
  end

endmodule

// File: rtl/m16_simd_accum.sv
// Multi-beat SIMD accumulate sequencer (IDLE -> ACC -> DONE).
// Optional abort port enabled by defining M16_ACC_ABORT_EN.
module m16_simd_accum
  import m16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_width,
  input  logic             i_cmd_sat,
  input  logic [CNT_W-1:0] i_cmd_count,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [15:0]      i_in_data,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [15:0]      o_res_data,
  output logic [3:0]       o_res_ovf,
  output logic             o_busy
`ifdef M16_ACC_ABORT_EN
  ,
  input  logic             i_abort
`endif
);

  state_e           r_state, w_nstate;
  logic [1:0]       r_width, w_nwidth;
  logic             r_sat, w_nsat;
  logic [CNT_W-1:0] r_rem, w_nrem;
  logic [15:0]      r_acc, w_nacc, w_sum;
  logic [3:0]       r_ovf, w_novf, w_aovf;
  logic             w_abort;

`ifdef M16_ACC_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  m16_simd_add u_add (
    .i_a     (r_acc),
    .i_b     (i_in_data),
    .i_width (r_width),
    .i_sat   (r_sat),
    .o_sum   (w_sum),
    .o_ovf   (w_aovf)
  );

  // All handshake outputs decode straight from the state register.
  assign o_cmd_ready = (r_state == IDLE);
  assign o_in_ready  = (r_state == ACC);
  assign o_res_valid = (r_state == DONE);
  assign o_busy      = (r_state != IDLE);
  assign o_res_data  = r_acc;
  assign o_res_ovf   = r_ovf;

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_width <= W4;
      r_sat   <= 1'b0;
      r_rem   <= '0;
      r_acc   <= '0;
      r_ovf   <= '0;
    end else begin
      r_state <= w_nstate;
      r_width <= w_nwidth;
      r_sat   <= w_nsat;
      r_rem   <= w_nrem;
      r_acc   <= w_nacc;
      r_ovf   <= w_novf;
    end
  end

  // Next-state and datapath updates; abort overrides everything outside IDLE.
  always_comb begin
    w_nstate = r_state;
    w_nwidth = r_width;
    w_nsat   = r_sat;
    w_nrem   = r_rem;
    w_nacc   = r_acc;
    w_novf   = r_ovf;
    case (r_state)
      IDLE: if (i_cmd_valid) begin
        w_nwidth = norm_width(i_cmd_width);
        w_nsat   = i_cmd_sat;
        w_nrem   = i_cmd_count;
        w_nacc   = '0;
        w_novf   = '0;
        w_nstate = (i_cmd_count == '0) ? DONE : ACC;
      end
      ACC: if (i_in_valid) begin
        w_nacc = w_sum;
        w_novf = r_ovf | w_aovf;
        w_nrem = r_rem - 1'b1;
        if (r_rem == {{(CNT_W-1){1'b0}}, 1'b1}) w_nstate = DONE;
      end
      DONE: if (i_res_ready) w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
    if (w_abort && r_state != IDLE) begin
      w_nstate = IDLE;
      w_nacc   = '0;
      w_novf   = '0;
    end
  end

endmodule

// File: tb/tb_m16_simd_accum.sv
module tb_m16_simd_accum;
  import m16_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_sat = 1'b0;
  logic [1:0]  cmd_width = 2'b00;
  logic [7:0]  cmd_count = '0;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] in_data = '0;
  logic        res_valid, res_ready = 1'b0;
  logic [15:0] res_data;
  logic [3:0]  res_ovf;
  logic        busy;
`ifdef M16_ACC_ABORT_EN
  logic        abort = 1'b0;
`endif

  always #5 clk = ~clk;

  m16_simd_accum #(.CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_width(cmd_width), .i_cmd_sat(cmd_sat), .i_cmd_count(cmd_count),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_data(res_data), .o_res_ovf(res_ovf), .o_busy(busy)
`ifdef M16_ACC_ABORT_EN
    , .i_abort(abort)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: per-lane signed integer sums.
  logic [15:0] m_acc = '0;
  logic [3:0]  m_ovf = '0;
  logic [1:0]  m_w = W16;
  logic        m_sat = 1'b0;
  int          m_rem = 0;
  bit          m_expect = 1'b0;
  bit          m_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_step(input logic [15:0] d);
    int nl, lw, mask, hi, lo, av, bv, s, acc;
    nl   = (m_w == W4) ? 4 : (m_w == W8) ? 2 : 1;
    lw   = 16 / nl;
    mask = (1 << lw) - 1;
    hi   = (1 << (lw - 1)) - 1;
    lo   = -(1 << (lw - 1));
    acc  = int'(m_acc);
    for (int i = 0; i < nl; i++) begin
      av = (acc >> (i * lw)) & mask;
      bv = (int'(d) >> (i * lw)) & mask;
      if (av > hi) av -= (1 << lw);
      if (bv > hi) bv -= (1 << lw);
      s = av + bv;
      if (s > hi || s < lo) begin
        m_ovf[(i + 1) * lw / 4 - 1] = 1'b1;
        if (m_sat) s = (s > hi) ? hi : lo;
      end
      acc = (acc & ~(mask << (i * lw))) | ((s & mask) << (i * lw));
    end
    m_acc = acc[15:0];
  endtask

  // Every active cycle: handshake status and result must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("res_valid", res_valid, m_expect);
      check("busy", busy, m_busy);
      if (res_valid && m_expect) begin
        check("res_data", res_data, m_acc);
        check("res_ovf", res_ovf, m_ovf);
      end
    end
  end

  task automatic cmd(input logic [1:0] w, input logic s, input int cnt);
    int to = 0;
    cmd_valid = 1'b1; cmd_width = w; cmd_sat = s; cmd_count = cnt[7:0];
    while (!cmd_ready && to < 50) begin @(posedge clk); #1; to++; end
    if (to >= 50) check("cmd_timeout", 1, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    m_w = (w == 2'b11) ? W16 : w; m_sat = s; m_acc = '0; m_ovf = '0;
    m_busy = 1'b1; m_rem = cnt; m_expect = (cnt == 0);
    check("in_ready_after_accept", in_ready, cnt != 0);
    check("res_valid_after_accept", res_valid, cnt == 0);
  endtask

  task automatic beat(input logic [15:0] d, input int gap);
    int to = 0;
    repeat (gap) begin in_valid = 1'b0; @(posedge clk); #1; end
    in_valid = 1'b1; in_data = d;
    while (!in_ready && to < 50) begin @(posedge clk); #1; to++; end
    if (to >= 50) check("beat_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 16'hDEAD;
    m_step(d);
    m_rem--;
    if (m_rem == 0) m_expect = 1'b1;
  endtask

  task automatic result(input int hold, output logic [15:0] d, output logic [3:0] ov);
    int to = 0;
    res_ready = 1'b0;
    while (!res_valid && to < 50) begin @(posedge clk); #1; to++; end
    if (to >= 50) check("res_timeout", 1, 0);
    d = res_data; ov = res_ovf;
    repeat (hold) begin
      @(posedge clk); #1;
      check("cmd_ready_while_held", cmd_ready, 0);
      check("res_data_stable", res_data, d);
      check("res_ovf_stable", res_ovf, ov);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0; m_expect = 1'b0; m_busy = 1'b0;
    check("cmd_ready_after_res", cmd_ready, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_ovf"}, res_ovf, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [3:0]  ov;
    #12;
    check_reset_vals("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // W16 saturating positive overflow
    cmd(W16, 1'b1, 2); beat(16'h7000, 0); beat(16'h2000, 0);
    result(0, d, ov); check("w16_sat_data", d, 16'h7FFF); check("w16_sat_ovf", ov, 4'b1000);

    // W4 wrap then saturate
    cmd(W4, 1'b0, 2); beat(16'h7777, 0); beat(16'h1111, 0);
    result(0, d, ov); check("w4_wrap_data", d, 16'h8888); check("w4_wrap_ovf", ov, 4'b1111);
    cmd(W4, 1'b1, 2); beat(16'h7777, 0); beat(16'h1111, 0);
    result(0, d, ov); check("w4_sat_data", d, 16'h7777); check("w4_sat_ovf", ov, 4'b1111);

    // W8 mixed lanes: only upper lane overflows negative
    cmd(W8, 1'b1, 2); beat(16'h8080, 0); beat(16'hFF01, 0);
    result(0, d, ov); check("w8_sat_data", d, 16'h8081); check("w8_sat_ovf", ov, 4'b1000);

    // W4 negative saturation keeps accumulating from the clamp
    cmd(W4, 1'b1, 3); beat(16'h8888, 0); beat(16'h8888, 0); beat(16'h1234, 0);
    result(0, d, ov); check("w4_negsat_data", d, 16'h9ABC); check("w4_negsat_ovf", ov, 4'b1111);

    // Reserved width encoding behaves as 16-bit
    cmd(2'b11, 1'b0, 2); beat(16'h8000, 0); beat(16'h8000, 0);
    result(0, d, ov); check("w11_data", d, 16'h0000); check("w11_ovf", ov, 4'b1000);

    // Zero-beat command
    cmd(W16, 1'b0, 0);
    check("cnt0_in_ready", in_ready, 0);
    result(0, d, ov); check("cnt0_data", d, 16'h0000); check("cnt0_ovf", ov, 4'b0000);

    // in_valid while idle must not be consumed; then gapped beats and held result
    in_valid = 1'b1; in_data = 16'h1234;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    cmd(W8, 1'b0, 3); beat(16'h0102, 1); beat(16'h0304, 1); beat(16'h0506, 1);
    result(3, d, ov); check("bp_data", d, 16'h090C); check("bp_ovf", ov, 4'b0000);

    // Reset in the middle of an accumulation
    cmd(W16, 1'b0, 3); beat(16'h0100, 0);
    rst_n = 1'b0; m_busy = 1'b0; m_expect = 1'b0;
    #1 check_reset_vals("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    cmd(W16, 1'b0, 1); beat(16'h0005, 0);
    result(0, d, ov); check("post_rst_data", d, 16'h0005); check("post_rst_ovf", ov, 4'b0000);

`ifdef M16_ACC_ABORT_EN
    // Abort in the middle of an accumulation
    cmd(W16, 1'b0, 3); beat(16'h0100, 0);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    m_busy = 1'b0; m_expect = 1'b0;
    check_reset_vals("abort");
    cmd(W16, 1'b0, 1); beat(16'h0005, 0);
    result(0, d, ov); check("post_abort_data", d, 16'h0005); check("post_abort_ovf", ov, 4'b0000);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
